// File: rtl/serial_shifter.sv
// serial_shifter: one-bit-per-cycle SRL / ROL / saturating SSL engine
// with start/busy/done handshake and registered result and flags.
module serial_shifter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [3:0]       shift_val,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shift_out,
  output logic             ovfl,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] M_SRL  = 2'b00;
  localparam logic [1:0] M_ROL  = 2'b01;
  localparam logic [1:0] M_SSL  = 2'b10;
  localparam logic [1:0] M_PASS = 2'b11;

  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [3:0]       r_cnt;
  logic [1:0]       r_mode;
  logic             r_sign;
  logic             r_sticky;

  logic             w_accept;
  logic [WIDTH-1:0] w_step;
  logic             w_step_sticky;
  logic [WIDTH-1:0] w_fin_work;
  logic             w_fin_sticky;
  logic             w_fin_sign;
  logic [1:0]       w_fin_mode;
  logic [WIDTH-1:0] w_result;
  logic             w_load;

  assign w_accept = (r_state == S_IDLE) && start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((shift_val != 4'd0) && (mode != M_PASS))
            w_state_nxt = S_SHIFT;
          else
            w_state_nxt = S_DONE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == 4'd1) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // One 1-bit step of the working register
  always_comb begin
    w_step = r_work;
    unique case (r_mode)
      M_SRL:   w_step = {1'b0, r_work[WIDTH-1:1]};
      M_ROL:   w_step = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
      M_SSL:   w_step = {r_work[WIDTH-2:0], 1'b0};
      default: w_step = r_work;
    endcase
    w_step_sticky = r_sticky |
      ((r_mode == M_SSL) && (r_work[WIDTH-1] != r_work[WIDTH-2]));
  end

  // Result selection for the edge that enters DONE
  always_comb begin
    if (r_state == S_IDLE) begin
      w_fin_work   = shift_in;
      w_fin_sticky = 1'b0;
      w_fin_sign   = shift_in[WIDTH-1];
      w_fin_mode   = mode;
    end else begin
      w_fin_work   = w_step;
      w_fin_sticky = w_step_sticky;
      w_fin_sign   = r_sign;
      w_fin_mode   = r_mode;
    end
    if ((w_fin_mode == M_SSL) && w_fin_sticky)
      w_result = w_fin_sign ? SAT_NEG : SAT_POS;
    else
      w_result = w_fin_work;
    w_load = (w_state_nxt == S_DONE) && (r_state != S_DONE);
  end

  // Operand capture and per-cycle shifting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work   <= '0;
      r_cnt    <= '0;
      r_mode   <= '0;
      r_sign   <= 1'b0;
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_work   <= shift_in;
      r_cnt    <= shift_val;
      r_mode   <= mode;
      r_sign   <= shift_in[WIDTH-1];
      r_sticky <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_work   <= w_step;
      r_cnt    <= r_cnt - 4'd1;
      r_sticky <= w_step_sticky;
    end
  end

  // Registered result and flags, updated only on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_out <= '0;
      ovfl      <= 1'b0;
      zero      <= 1'b0;
    end else if (w_load) begin
      shift_out <= w_result;
      ovfl      <= w_fin_sticky;
      zero      <= (w_result == '0);
    end
  end

endmodule

// File: tb/tb_serial_shifter.sv
// tb_serial_shifter: directed and random checks of serial_shifter
// against an arithmetic reference model.
module tb_serial_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] shift_in = '0;
  logic [3:0]  shift_val = '0;
  logic [1:0]  mode = '0;
  logic        busy;
  logic        done;
  logic [15:0] shift_out;
  logic        ovfl;
  logic        zero;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_out = '0;

  serial_shifter #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .shift_in  (shift_in),
    .shift_val (shift_val),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .shift_out (shift_out),
    .ovfl      (ovfl),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic void model(
    input  logic [15:0] a,
    input  logic [3:0]  n,
    input  logic [1:0]  m,
    output logic [15:0] r,
    output logic        o,
    output int          lat
  );
    longint v;
    o = 1'b0;
    r = a;
    lat = (m == 2'b11) ? 0 : int'(n);
    case (m)
      2'b00: r = a >> n;
      2'b01: r = (a << n) | (a >> (16 - int'(n)));
      2'b10: begin
        v = longint'($signed(a)) * (64'sd1 <<< n);
        if (v > 32767) begin
          r = 16'h7FFF; o = 1'b1;
        end else if (v < -32768) begin
          r = 16'h8000; o = 1'b1;
        end else begin
          r = v[15:0];
        end
      end
      default: r = a;
    endcase
  endfunction

  task automatic issue(input logic [15:0] a, input logic [3:0] n,
                       input logic [1:0] m);
    shift_in  = a;
    shift_val = n;
    mode      = m;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic collect(
    input  logic [15:0] prev,
    output int          lat,
    output logic [15:0] so,
    output logic        ov,
    output logic        z,
    output bit          busy_ok,
    output bit          hold_ok
  );
    lat = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (shift_out !== prev) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
    else if (busy !== 1'b1) busy_ok = 1'b0;
    so = shift_out;
    ov = ovfl;
    z  = zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, shift_out, ovfl, zero} !== 20'h0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b out=%h ov=%b z=%b want all 0",
               busy, done, shift_out, ovfl, zero);
    end
    rst = 1'b0;
    @(negedge clk);
    last_out = 16'h0;
  endtask

  task automatic test_directed();
    logic [15:0] din [10] = '{16'h8001, 16'h8001, 16'h8001, 16'h0003,
                              16'h4000, 16'hC000, 16'hC000, 16'h1234,
                              16'hABCD, 16'h0001};
    logic [3:0]  dn  [10] = '{4'd4, 4'd1, 4'd15, 4'd2, 4'd1, 4'd2, 4'd1,
                              4'd0, 4'd7, 4'd1};
    logic [1:0]  dm  [10] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10,
                              2'b10, 2'b00, 2'b11, 2'b00};
    logic [15:0] dq  [10] = '{16'h0800, 16'h0003, 16'hC000, 16'h000C,
                              16'h7FFF, 16'h8000, 16'h8000, 16'h1234,
                              16'hABCD, 16'h0000};
    logic        dov [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic        dz  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int          dl  [10] = '{4, 1, 15, 2, 1, 2, 1, 0, 0, 1};
    int lat;
    logic [15:0] so;
    logic ov, z;
    bit bok, hok;
    for (int i = 0; i < 10; i++) begin
      issue(din[i], dn[i], dm[i]);
      collect(last_out, lat, so, ov, z, bok, hok);
      checks++;
      if (lat !== dl[i] || !bok || !hok) begin
        errors++;
        $display("FAIL dir%0d timing: lat=%0d busy_ok=%0b hold_ok=%0b want lat=%0d",
                 i, lat, bok, hok, dl[i]);
      end
      checks++;
      if (so !== dq[i] || ov !== dov[i] || z !== dz[i]) begin
        errors++;
        $display("FAIL dir%0d result: out=%h ov=%b z=%b want out=%h ov=%b z=%b",
                 i, so, ov, z, dq[i], dov[i], dz[i]);
      end
      last_out = dq[i];
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || shift_out !== dq[i]) begin
        errors++;
        $display("FAIL dir%0d idle: busy=%b done=%b out=%h want 0 0 %h",
                 i, busy, done, shift_out, dq[i]);
      end
    end
  endtask

  task automatic test_handshake();
    logic [15:0] a, b, q1, q2;
    logic o1, o2;
    int l1, l2, lat;
    logic [15:0] so;
    logic ov, z;
    bit bok, hok;
    a = 16'(32'h8000 | $urandom_range(1, 16'h7FFF));
    b = ~a;
    model(a, 4'd10, 2'b00, q1, o1, l1);
    model(b, 4'd3, 2'b01, q2, o2, l2);
    shift_in = a; shift_val = 4'd10; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    shift_in = b; shift_val = 4'd3; mode = 2'b01;
    collect(last_out, lat, so, ov, z, bok, hok);
    checks++;
    if (lat !== 10 || !bok || !hok || so !== q1 || ov !== o1) begin
      errors++;
      $display("FAIL hs_first: lat=%0d out=%h ov=%b bok=%0b hok=%0b want lat=10 out=%h ov=%b",
               lat, so, ov, bok, hok, q1, o1);
    end
    last_out = q1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || shift_out !== q1) begin
      errors++;
      $display("FAIL hs_idle_gap: busy=%b done=%b out=%h want 0 0 %h",
               busy, done, shift_out, q1);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || shift_out !== q1) begin
      errors++;
      $display("FAIL hs_reaccept: busy=%b out=%h want 1 %h", busy, shift_out, q1);
    end
    collect(last_out, lat, so, ov, z, bok, hok);
    checks++;
    if (lat !== l2 || !bok || !hok || so !== q2 || ov !== o2) begin
      errors++;
      $display("FAIL hs_second: lat=%0d out=%h ov=%b want lat=%0d out=%h ov=%b",
               lat, so, ov, l2, q2, o2);
    end
    last_out = q2;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] a, q;
    logic [3:0] n;
    logic [1:0] m;
    logic o;
    int el, lat;
    logic [15:0] so;
    logic ov, z;
    bit bok, hok;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      if (i % 4 == 0) a = 16'($urandom_range(0, 255));
      n = 4'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      model(a, n, m, q, o, el);
      issue(a, n, m);
      collect(last_out, lat, so, ov, z, bok, hok);
      checks++;
      if (lat !== el || !bok || !hok || so !== q || ov !== o ||
          z !== (q == 16'h0)) begin
        errors++;
        $display("FAIL rnd%0d in=%h n=%0d m=%0d: lat=%0d out=%h ov=%b z=%b want lat=%0d out=%h ov=%b",
                 i, a, n, m, lat, so, ov, z, el, q, o);
      end
      last_out = q;
      @(negedge clk);
    end
  endtask

  task automatic test_midop_reset();
    int lat;
    logic [15:0] so;
    logic ov, z;
    bit bok, hok, seen;
    issue(16'h00F0, 4'd4, 2'b01);
    collect(last_out, lat, so, ov, z, bok, hok);
    checks++;
    if (lat !== 4 || so !== 16'h0F00 || ov !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_op: lat=%0d out=%h ov=%b want 4 0f00 0", lat, so, ov);
    end
    @(negedge clk);
    issue(16'h4001, 4'd8, 2'b10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, shift_out, ovfl, zero} !== 20'h0) begin
      errors++;
      $display("FAIL midop_reset: busy=%b done=%b out=%h ov=%b z=%b want all 0",
               busy, done, shift_out, ovfl, zero);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_abort: done/busy seen after reset, want none");
    end
    last_out = 16'h0;
    issue(16'h0001, 4'd8, 2'b10);
    collect(last_out, lat, so, ov, z, bok, hok);
    checks++;
    if (lat !== 8 || !bok || !hok || so !== 16'h0100 || ov !== 1'b0 ||
        z !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_op: lat=%0d out=%h ov=%b z=%b want 8 0100 0 0",
               lat, so, ov, z);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_random();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
